hex_page_driver: RTL and testbench
==================================

Name: hex_page_driver

Overview:
- Upstream feeder for the four per-digit hex-to-7-segment decoders on the board debug display.
- Captures a 32-bit debug word on a strobe and presents one 16-bit halfword ("page") as four registered nibbles.
- A debounced push-button flips between the low and high halfword pages.
- Sits between processor debug taps and the segment decoders. The segment decoders stay purely combinational.

Parameters:
- DEBOUNCE_CYCLES, 50000, number of consecutive stable synchronised button samples needed to accept a press or release; must be ≥1.
- SCROLL_CYCLES, 100000000, auto-scroll period in clocks; used only when HEX_AUTO_SCROLL_EN is defined; must be ≥2.

Ports:
- clk  input  1  system clock, all state on the rising edge
- rst  input  1  asynchronous, active-high reset
- inWord  input  32  debug word to display
- inCapture  input  1  sampled each edge; when 1, inWord is captured
- inPageBtn  input  1  raw push-button, active-high (pressed = 1), asynchronous to clk
- outNibbles  output  16  registered display halfword; [15:12] drives the leftmost digit decoder, [3:0] the rightmost
- outPage  output  1  current page (0 = inWord[15:0], 1 = inWord[31:16]), for the page LED

Behaviour:
- Reset (async, any time, including mid-debounce or mid-scroll): all of the following clear immediately.
  - capWord=0, page=0, debounce state IDLE, debounce counter=0, both synchroniser flops=0, scroll timer=0.
  - outNibbles=16'h0000 and outPage=0.
- Capture: on an edge with inCapture=1, capWord<=inWord. Otherwise capWord holds.
- Output register: every edge, outNibbles<=(page_next ? capWord_next[31:16] : capWord_next[15:0]) and outPage<=page_next.
  - A capture or toggle at edge N is therefore visible on the outputs at edge N.
  - Latency is 1 edge from the sampled strobe.
- Simultaneous capture and page toggle on the same edge: both apply. The output shows the new word's new page.
- Button synchroniser: two flops, sync1<=inPageBtn, sync2<=sync1. Only sync2 feeds the FSM.
- Debounce FSM. Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - IDLE: if sync2=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - if sync2=0, go to IDLE with cnt=0;
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and generate a one-cycle toggle (page<=~page on this edge);
    - else cnt++.
  - PRESSED: if sync2=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - if sync2=1, go to PRESSED with cnt=0;
    - else if cnt==DEBOUNCE_CYCLES-1, go to IDLE;
    - else cnt++.
  - Release never toggles. A held button gives exactly one toggle.
- Press latency: first edge sampling inPageBtn=1 is edge 1.
  - PRESS_WAIT is entered at edge 3.
  - Page toggles at edge DEBOUNCE_CYCLES+3 if the button stays high throughout.
- Page wraps 1→0 on toggle. There is no other page source without the optional feature.

Optional Feature:
- Macro HEX_AUTO_SCROLL_EN.
- Defined:
  - A scroll timer counts 0..SCROLL_CYCLES-1 and wraps.
  - On the edge where the timer equals SCROLL_CYCLES-1, the page toggles.
  - A button toggle clears the timer to 0 on the same edge.
  - If a button toggle and scroll terminal coincide, the page toggles exactly once and the timer clears to 0.
  - Captures do not affect the timer.
- Undefined: no timer logic is present, and the page changes only via the button.

Test Plan:
Benches use DEBOUNCE_CYCLES=4 and SCROLL_CYCLES=10.
1. Pulse rst=1 asynchronously mid-run (page=1, outNibbles=16'hDEAD) -> outNibbles=16'h0000 and outPage=0 before the next clk edge. They stay so until after rst=0.
2. inWord=32'hDEADBEEF with inCapture=1 for one edge -> outNibbles=16'hBEEF at that edge. Then inWord=32'h0 with inCapture=0 -> outNibbles stays 16'hBEEF.
3. After test 2, hold inPageBtn=1 for 20 cycles -> outPage=1 and outNibbles=16'hDEAD at edge 7, with no further toggle while held. Release for ≥7 cycles, then press again for 10 cycles -> back to 16'hBEEF and page 0.
4. Bounce: inPageBtn pattern of 3 cycles high, 1 low, repeated 5 times, then low -> no toggle, and outNibbles stays 16'hBEEF.
5. Arrange the debounced toggle edge to coincide with inCapture=1 and inWord=32'h12345678, from page 0 -> outPage=1 and outNibbles=16'h1234 on that edge.
6. With HEX_AUTO_SCROLL_EN, idle after reset:
   - outPage toggles every 10 cycles.
   - A button toggle at timer=6 flips the page and makes the next auto toggle occur 10 cycles later.
   - Without the macro, outPage stays 0 for 100 idle cycles.

Source files
------------

// File: rtl/hex_page_driver.sv
`default_nettype none
// ============================================================================
//  Module      : hex_page_driver
//  Description : Upstream feeder for the four per-digit hex-to-7-segment
//                decoders on the board debug display. A 32-bit debug word is
//                captured on a strobe. One 16-bit halfword ("page") of that
//                word is presented as four registered nibbles. A debounced
//                push-button flips between the low and high pages.
//
//  Optional    : `define HEX_AUTO_SCROLL_EN adds a free-running scroll timer.
//                The timer flips the page every SCROLL_CYCLES clocks. A button
//                toggle restarts the timer.
//
//  Parameters  : DEBOUNCE_CYCLES - number of consecutive stable synchronised
//                                  samples needed to accept a press or a
//                                  release (>= 1)
//                SCROLL_CYCLES   - auto-scroll period in clocks (>= 2); used
//                                  only with HEX_AUTO_SCROLL_EN
//
//  Ports       : clk        in   1  system clock, rising edge
//                rst        in   1  asynchronous active-high reset
//                inWord     in  32  debug word to display
//                inCapture  in   1  capture strobe for inWord
//                inPageBtn  in   1  raw push-button, active-high, async
//                outNibbles out 16  registered halfword, [15:12] = leftmost
//                outPage    out  1  current page (0 = [15:0], 1 = [31:16])
//
//  Revision    : 1.0  initial release
// ============================================================================
module hex_page_driver #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCROLL_CYCLES   = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inWord,
    input  logic        inCapture,
    input  logic        inPageBtn,
    output logic [15:0] outNibbles,
    output logic        outPage
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------------
    generate
        if (DEBOUNCE_CYCLES < 1 || SCROLL_CYCLES < 2) begin : g_param_check
            $error("hex_page_driver: DEBOUNCE_CYCLES must be >= 1 and SCROLL_CYCLES >= 2");
        end
    endgenerate

    localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

    // ------------------------------------------------------------------------
    // Captured debug word
    // ------------------------------------------------------------------------
    logic [31:0] cap_word_q;
    logic [31:0] cap_word_d;

    always_comb begin
        cap_word_d = cap_word_q;
        if (inCapture) begin
            cap_word_d = inWord;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_word_q <= 32'h0000_0000;
        end else begin
            cap_word_q <= cap_word_d;
        end
    end

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous push-button
    // ------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= inPageBtn;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce FSM
    // A press must stay high for DEBOUNCE_CYCLES samples after the first
    // high sample before it is accepted. Only acceptance of a press produces
    // a toggle. Release is debounced the same way so that release bounce
    // cannot re-arm the press path.
    // ------------------------------------------------------------------------
    deb_state_t       state_q;
    deb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_toggle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        btn_toggle = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d    = ST_PRESSED;
                    cnt_d      = '0;
                    btn_toggle = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Page toggle sources
    // ------------------------------------------------------------------------
    logic page_toggle;

`ifdef HEX_AUTO_SCROLL_EN
    localparam int               TMR_W      = $clog2(SCROLL_CYCLES);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(SCROLL_CYCLES - 1);

    logic [TMR_W-1:0] scroll_tmr_q;
    logic [TMR_W-1:0] scroll_tmr_d;
    logic             scroll_hit;

    // The timer restarts on either toggle source. When both coincide, the
    // OR below still gives a single page flip.
    always_comb begin
        scroll_hit   = (scroll_tmr_q == C_TMR_LAST);
        scroll_tmr_d = scroll_tmr_q + 1'b1;
        if (btn_toggle || scroll_hit) begin
            scroll_tmr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scroll_tmr_q <= '0;
        end else begin
            scroll_tmr_q <= scroll_tmr_d;
        end
    end

    assign page_toggle = btn_toggle | scroll_hit;
`else
    assign page_toggle = btn_toggle;
`endif

    // ------------------------------------------------------------------------
    // Page register and output register
    // Outputs are formed from the next-state values. A capture or toggle
    // sampled at an edge is therefore visible straight after that same edge.
    // ------------------------------------------------------------------------
    logic        page_q;
    logic        page_d;
    logic [15:0] nibbles_d;

    always_comb begin
        page_d    = page_q ^ page_toggle;
        nibbles_d = page_d ? cap_word_d[31:16] : cap_word_d[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_q     <= 1'b0;
            outNibbles <= 16'h0000;
            outPage    <= 1'b0;
        end else begin
            page_q     <= page_d;
            outNibbles <= nibbles_d;
            outPage    <= page_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_page_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_page_driver
//  Description : Self-checking bench for hex_page_driver. Directed scenarios
//                are followed by a randomized phase. All cycles are compared
//                against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_page_driver;

    localparam int C_DEB = 4;
    localparam int C_SCR = 10;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [31:0] inWord    = 32'h0;
    logic        inCapture = 1'b0;
    logic        inPageBtn = 1'b0;
    logic [15:0] outNibbles;
    logic        outPage;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hex_page_driver #(
        .DEBOUNCE_CYCLES (C_DEB),
        .SCROLL_CYCLES   (C_SCR)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .inWord     (inWord),
        .inCapture  (inCapture),
        .inPageBtn  (inPageBtn),
        .outNibbles (outNibbles),
        .outPage    (outPage)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // The button is debounced as a level. It flips once the synchronised
    // sample has disagreed with the accepted level for DEB+1 consecutive
    // edges. A flip to "pressed" toggles the page.
    // ------------------------------------------------------------------------
    logic [31:0] m_word;
    bit          m_page;
    bit          m_s1, m_s2;
    bit          m_level;
    int          m_run;
    int          m_timer;

    task automatic model_reset();
        m_word  = 32'h0;
        m_page  = 1'b0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        m_timer = 0;
    endtask

    task automatic model_edge(input logic [31:0] word, input bit cap, input bit btn);
        bit tog;
        bit flip;
        tog = 1'b0;
        if (m_s2 != m_level) begin
            m_run++;
            if (m_run == C_DEB + 1) begin
                m_level = m_s2;
                m_run   = 0;
                tog     = m_level;
            end
        end else begin
            m_run = 0;
        end
        flip = tog;
`ifdef HEX_AUTO_SCROLL_EN
        if (m_timer == C_SCR - 1) flip = 1'b1;
        m_timer = flip ? 0 : m_timer + 1;
`endif
        if (flip) m_page = ~m_page;
        m_s2 = m_s1;
        m_s1 = btn;
        if (cap) m_word = word;
    endtask

    function automatic logic [15:0] m_nib();
        return m_page ? m_word[31:16] : m_word[15:0];
    endfunction

    // ------------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called with clk low; drives one edge and compares against the model.
    task automatic cyc(input logic [31:0] word, input bit cap, input bit btn);
        inWord    = word;
        inCapture = cap;
        inPageBtn = btn;
        @(posedge clk);
        model_edge(word, cap, btn);
        #1;
        check_eq("nib", outNibbles, m_nib());
        check_eq("page", outPage, m_page);
        @(negedge clk);
    endtask

    // Called with clk low; asserts reset between edges and holds it over edges.
    task automatic pulse_reset(input int hold_edges);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_nib", outNibbles, 16'h0000);
        check_eq("rst_async_page", outPage, 1'b0);
        for (int k = 0; k < hold_edges; k++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_nib", outNibbles, 16'h0000);
            check_eq("rst_hold_page", outPage, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        bit          b;
        int          run_len;
        logic [31:0] w;

        model_reset();
        #1;
        check_eq("por_nib", outNibbles, 16'h0000);
        check_eq("por_page", outPage, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("por_hold_nib", outNibbles, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

`ifdef HEX_AUTO_SCROLL_EN
        // Auto-scroll every C_SCR edges; button toggle at timer=6 restarts it.
        for (int n = 1; n <= 45; n++) begin
            cyc(32'hCAFE_F00D, (n == 3), (n >= 21 && n <= 30));
            if (n == 9)  check_eq("scr_pre", outPage, 1'b0);
            if (n == 10) begin
                check_eq("scr_first", outPage, 1'b1);
                check_eq("scr_first_nib", outNibbles, 16'hCAFE);
            end
            if (n == 20) check_eq("scr_second", outPage, 1'b0);
            if (n == 26) check_eq("btn_pre", outPage, 1'b0);
            if (n == 27) check_eq("btn_toggle", outPage, 1'b1);
            if (n == 36) check_eq("scr_restart_pre", outPage, 1'b1);
            if (n == 37) check_eq("scr_restart", outPage, 1'b0);
        end
`else
        // Capture and hold
        cyc(32'hDEAD_BEEF, 1'b1, 1'b0);
        check_eq("cap_beef", outNibbles, 16'hBEEF);
        cyc(32'h0, 1'b0, 1'b0);
        check_eq("hold_beef", outNibbles, 16'hBEEF);

        // Held button: exactly one toggle, at the 7th edge
        for (int i = 1; i <= 20; i++) begin
            cyc(32'h0, 1'b0, 1'b1);
            if (i == 6) check_eq("press_pre", outPage, 1'b0);
            if (i == 7) begin
                check_eq("press_page", outPage, 1'b1);
                check_eq("press_dead", outNibbles, 16'hDEAD);
            end
        end
        check_eq("held_once", outPage, 1'b1);
        repeat (8) cyc(32'h0, 1'b0, 1'b0);
        check_eq("release_no_toggle", outPage, 1'b1);
        repeat (10) cyc(32'h0, 1'b0, 1'b1);
        check_eq("press2_page", outPage, 1'b0);
        check_eq("press2_beef", outNibbles, 16'hBEEF);
        repeat (10) cyc(32'h0, 1'b0, 1'b0);

        // Bounce shorter than the debounce window
        for (int r = 0; r < 5; r++) begin
            repeat (3) cyc(32'h0, 1'b0, 1'b1);
            cyc(32'h0, 1'b0, 1'b0);
        end
        repeat (8) cyc(32'h0, 1'b0, 1'b0);
        check_eq("bounce_page", outPage, 1'b0);
        check_eq("bounce_beef", outNibbles, 16'hBEEF);

        // Toggle coinciding with a capture
        for (int i = 1; i <= 7; i++) begin
            cyc((i == 7) ? 32'h1234_5678 : 32'h0, (i == 7), 1'b1);
        end
        check_eq("coinc_page", outPage, 1'b1);
        check_eq("coinc_nib", outNibbles, 16'h1234);
        repeat (10) cyc(32'h0, 1'b0, 1'b0);

        // Async reset mid-run while showing page 1 = DEAD
        cyc(32'hDEAD_BEEF, 1'b1, 1'b0);
        check_eq("pre_rst_dead", outNibbles, 16'hDEAD);
        pulse_reset(2);

        // No page source other than the button
        repeat (100) cyc(32'h0, 1'b0, 1'b0);
        check_eq("idle_page", outPage, 1'b0);
`endif

        // Randomized phase
        b       = 1'b0;
        run_len = 0;
        for (int n = 0; n < 1500; n++) begin
            if (run_len == 0) begin
                b       = $urandom_range(0, 1);
                run_len = $urandom_range(1, 12);
            end
            run_len--;
            w = $urandom;
            cyc(w, ($urandom_range(0, 3) == 0), b);
            if ($urandom_range(0, 299) == 0) pulse_reset(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
